// File: rtl/convolution_coprocessor_pkg.sv
// Shared types and constants for the convolution coprocessor result path.
package convolution_coprocessor_pkg;

  localparam int unsigned DEF_SIZE_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    STREAM,
    DONE
  } state_e;

endpackage

// File: rtl/convolution_coprocessor_out_fifo.sv
// Two-entry fall-through valid/ready FIFO; optional per-entry last flag
// is present when CONV_READER_LAST_EN is defined.
module convolution_coprocessor_out_fifo
  import convolution_coprocessor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
`ifdef CONV_READER_LAST_EN
  ,
  input  logic                  in_last,
  output logic                  out_last
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  empty, pop, wr, rd;
`ifdef CONV_READER_LAST_EN
  logic                  last_q [FIFO_DEPTH];
  logic                  last_d [FIFO_DEPTH];
`endif

  assign empty     = (count_q == 2'd0);
  assign out_valid = !empty || in_valid;
  assign out_data  = !empty ? mem_q[rd_ptr_q] : (in_valid ? in_data : '0);
`ifdef CONV_READER_LAST_EN
  assign out_last  = !empty ? last_q[rd_ptr_q] : (in_valid && in_last);
`endif
  assign count     = count_q;

  // An arriving word that is consumed while the FIFO is empty bypasses storage.
  assign pop = out_valid && out_ready;
  assign wr  = in_valid && !(empty && pop);
  assign rd  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
`ifdef CONV_READER_LAST_EN
    last_d = last_q;
`endif
    if (wr) begin
      mem_d[wr_ptr_q] = in_data;
`ifdef CONV_READER_LAST_EN
      last_d[wr_ptr_q] = in_last;
`endif
    end
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ rd;
    count_d  = count_q + 2'(wr) - 2'(rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
`ifdef CONV_READER_LAST_EN
      last_q   <= '{default: 1'b0};
`endif
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
`ifdef CONV_READER_LAST_EN
      last_q   <= last_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/convolution_coprocessor_realAdder.sv
// Plain unsigned adder shared across the convolution coprocessor datapath.
module convolution_coprocessor_realAdder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/convolution_coprocessor_result_reader.sv
// Drains result memory Z (sizeY+sizeH-1 samples) onto a valid/ready stream.
// Define CONV_READER_LAST_EN to add the m_last output.
module convolution_coprocessor_result_reader
  import convolution_coprocessor_pkg::*;
#(
  parameter int unsigned SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int unsigned ADDR_WIDTH = SIZE_WIDTH + 1,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE_WIDTH-1:0] sizeY,
  input  logic [SIZE_WIDTH-1:0] sizeH,
  output logic [ADDR_WIDTH-1:0] memZ_addr,
  output logic                  memZ_rd,
  input  logic [DATA_WIDTH-1:0] memZ_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef CONV_READER_LAST_EN
  ,
  output logic                  m_last
`endif
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0] size_z_q, size_z_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0] sum;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_count;
  logic                  issue, handshake;
`ifdef CONV_READER_LAST_EN
  logic                  inflight_last_q, inflight_last_d;
`endif

  convolution_coprocessor_realAdder #(
    .WIDTH(ADDR_WIDTH)
  ) u_size_adder (
    .a  (y_q),
    .b  (h_q),
    .sum(sum)
  );

  convolution_coprocessor_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_data  (memZ_data),
    .out_ready(m_ready),
    .out_valid(m_valid),
    .out_data (m_data),
    .count    (fifo_count)
`ifdef CONV_READER_LAST_EN
    ,
    .in_last  (inflight_last_q),
    .out_last (m_last)
`endif
  );

  assign handshake = m_valid && m_ready;
  assign memZ_rd   = issue;
  assign memZ_addr = rd_ptr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    h_d       = h_q;
    size_z_d  = size_z_q;
    rd_ptr_d  = rd_ptr_q;
    out_cnt_d = out_cnt_q;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          y_d     = ADDR_WIDTH'(sizeY);
          h_d     = ADDR_WIDTH'(sizeH);
          state_d = CALC;
        end
      end
      CALC: begin
        rd_ptr_d  = '0;
        out_cnt_d = '0;
        if (y_q == '0 || h_q == '0) begin
          size_z_d = '0;
          state_d  = DONE;
        end else begin
          size_z_d = sum - ADDR_WIDTH'(1);
          state_d  = STREAM;
        end
      end
      STREAM: begin
        // Credit check: stored words plus the read in flight never exceed FIFO capacity.
        issue = (rd_ptr_q < size_z_q) &&
                ((fifo_count + 2'(inflight_q)) < 2'(FIFO_DEPTH));
        if (issue) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        if (handshake) begin
          out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
          if (out_cnt_d == size_z_q) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
`ifdef CONV_READER_LAST_EN
    inflight_last_d = issue && (rd_ptr_q == size_z_q - ADDR_WIDTH'(1));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      y_q        <= '0;
      h_q        <= '0;
      size_z_q   <= '0;
      rd_ptr_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
`ifdef CONV_READER_LAST_EN
      inflight_last_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      h_q        <= h_d;
      size_z_q   <= size_z_d;
      rd_ptr_q   <= rd_ptr_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
`ifdef CONV_READER_LAST_EN
      inflight_last_q <= inflight_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_convolution_coprocessor_result_reader.sv
// Directed + randomized bench for the Z result reader against a queue-free
// reference: sample k of a transfer must equal Z[k], k = 0..sizeY+sizeH-2.
module tb_convolution_coprocessor_result_reader;

  localparam int SW = 5;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] sizeY, sizeH;
  logic [AW-1:0] memZ_addr;
  logic          memZ_rd;
  logic [DW-1:0] memZ_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
`ifdef CONV_READER_LAST_EN
  logic          m_last;
`endif

  logic [DW-1:0] zmem [64];
  int            total = 0;
  int            bad   = 0;

  convolution_coprocessor_result_reader #(
    .SIZE_WIDTH(SW),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sizeY    (sizeY),
    .sizeH    (sizeH),
    .memZ_addr(memZ_addr),
    .memZ_rd  (memZ_rd),
    .memZ_data(memZ_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done)
`ifdef CONV_READER_LAST_EN
    ,
    .m_last   (m_last)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM model; junk on the bus when no read was issued.
  always @(posedge clk) begin
    if (memZ_rd) memZ_data <= zmem[memZ_addr];
    else         memZ_data <= DW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_addr"},  32'(memZ_addr), 0);
    chk({tag, "_rd"},    32'(memZ_rd),   0);
    chk({tag, "_data"},  32'(m_data),    0);
    chk({tag, "_valid"}, 32'(m_valid),   0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_done"},  32'(done),      0);
`ifdef CONV_READER_LAST_EN
    chk({tag, "_last"},  32'(m_last),    0);
`endif
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run(input int y, input int h, input int mode, input int abort_after,
                     input bit poke, input bit keep_mem);
    int            sz, cyc, rd_cnt, acc, last_hs, budget;
    bit            fin, stall, rdy, got_v;
    logic [DW-1:0] prev_d;
    sz      = (y == 0 || h == 0) ? 0 : y + h - 1;
    budget  = sz * 12 + 40;
    cyc     = 0; rd_cnt = 0; acc = 0; last_hs = -1;
    fin     = 0; stall = 0; got_v = 0; prev_d = '0;
    if (!keep_mem) for (int i = 0; i < 64; i++) zmem[i] = DW'($urandom);
    @(negedge clk);
    sizeY = SW'(y); sizeH = SW'(h); start = 1'b1; m_ready = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 4) begin
        start = 1'b1; sizeY = 5'd1; sizeH = 5'd1;
      end
      if (cyc == 1) begin
        chk("calc_busy", 32'(busy), 1);
        chk("calc_rd", 32'(memZ_rd), 0);
      end
      if (memZ_rd) begin
        rd_cnt++;
        chk("rd_addr", 32'(memZ_addr), 32'(rd_cnt - 1));
        chk("rd_outstanding", 32'((rd_cnt - acc) <= 2), 1);
        chk("rd_bound", 32'(rd_cnt <= sz), 1);
        if (rd_cnt == 1) chk("first_rd_cycle", 32'(cyc), 2);
      end
      if (stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_d));
      end
      if (m_valid && !got_v) begin
        got_v = 1;
        if (mode == 0) chk("first_valid_cycle", 32'(cyc), 3);
      end
      if (done) begin
        chk("done_cycle", 32'(cyc), 32'((sz == 0) ? 2 : last_hs + 1));
        chk("done_accepted", 32'(acc), 32'(sz));
        chk("done_reads", 32'(rd_cnt), 32'(sz));
        fin = 1;
      end else begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        m_ready = rdy;
        if (m_valid && rdy) begin
          chk("m_data", 32'(m_data), 32'(zmem[acc[5:0]]));
`ifdef CONV_READER_LAST_EN
          chk("m_last", 32'(m_last), 32'(acc == sz - 1));
`endif
          acc++;
          if (acc == sz) last_hs = cyc;
        end
        stall  = m_valid && !rdy;
        prev_d = m_data;
        if (abort_after >= 0 && acc == abort_after) begin
          #1 rst_n = 1'b0;
          #1 chk_quiet("abort");
          @(negedge clk);
          rst_n = 1'b1;
          fin   = 1;
        end else if (cyc > budget) begin
          chk("timeout", 0, 1);
          fin = 1;
        end
      end
    end
    m_ready = 1'b0;
    if (abort_after < 0) begin
      @(negedge clk);
      chk("after_done", 32'(done), 0);
      chk("after_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sizeY = '0; sizeH = '0; m_ready = 1'b0;
    for (int i = 0; i < 64; i++) zmem[i] = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) zmem[i] = DW'($urandom);
    zmem[0] = 16'd10; zmem[1] = 16'd20; zmem[2] = 16'd30; zmem[3] = 16'd40;
    run(3, 2, 0, -1, 0, 1);
    run(4, 3, 1, -1, 0, 0);
    run(0, 5, 0, -1, 0, 0);
    run(1, 0, 2, -1, 0, 0);
    run(1, 1, 0, -1, 0, 0);
    run(31, 31, 0, -1, 0, 0);
    run(31, 31, 2, -1, 0, 0);
    run(5, 5, 0, 2, 0, 0);
    run(2, 2, 0, -1, 0, 0);
    run(6, 4, 2, -1, 1, 0);
    for (int k = 0; k < 4; k++)
      run($urandom_range(1, 31), $urandom_range(1, 31), 2, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
